alu_result_checker: RTL

Synthesizable self-check block that sits on the output side of the `alu` datapath and consumes the operand/function/result tuples that the stimulus side applies. It recomputes the expected result with an internal reference model and compares it against the observed `o_data_y`/`o_data_c`. It keeps pass/error counters and captures the first mismatch, so ALU regressions run on FPGA or in simulation without a waveform viewer.

---
 rtl/alu_result_checker.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_result_checker.sv
// alu_result_checker: recomputes ALU results, compares against observed y (and carry when
// ALU_CHK_CARRY_EN is defined), keeps saturating pass/error counters and captures the first mismatch.
module alu_result_checker #(
  parameter int BIT   = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_valid,
  input  logic [BIT-1:0]   i_data_a,
  input  logic [BIT-1:0]   i_data_b,
  input  logic [2:0]       i_func,
  input  logic [BIT-1:0]   i_data_y,
  input  logic             i_data_c,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_err,
  output logic [2:0]       o_err_func,
  output logic [BIT-1:0]   o_err_exp_y,
  output logic [BIT-1:0]   o_err_got_y
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic             accept;
  logic [BIT:0]     ref_w;
  logic             match;
  logic             s1_vld_q;
  logic [2:0]       s1_func_q;
  logic [BIT-1:0]   s1_exp_y_q, s1_got_y_q;
  logic [CNT_W-1:0] pass_q, err_cnt_q;
  logic             err_q;
  logic [2:0]       err_func_q;
  logic [BIT-1:0]   err_exp_y_q, err_got_y_q;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) state_q <= IDLE;
    else state_q <= state_d;
  // i_start wins over everything, including i_stop in the same cycle
  always_comb
    state_d = i_start ? RUN :
              (state_q == RUN && i_stop) ? DRAIN :
              (state_q == DRAIN) ? DONE : state_q;
  always_comb begin
    o_busy = (state_q == RUN) || (state_q == DRAIN);
    o_done = (state_q == DONE);
  end
  assign accept = (state_q == RUN) && i_valid && !i_start;
  // {carry, y} reference result
  always_comb begin
    ref_w = '0;
    case (i_func)
      3'd0: ref_w = {1'b0, i_data_a} + {1'b0, i_data_b};
      3'd1: ref_w = {1'b0, i_data_a} + {1'b0, ~i_data_b} + (BIT+1)'(1);
      3'd2: ref_w = {1'b0, i_data_a & i_data_b};
      3'd3: ref_w = {1'b0, i_data_a | i_data_b};
      3'd4: ref_w = {1'b0, i_data_a ^ i_data_b};
      3'd5: ref_w = {1'b0, ~(i_data_a | i_data_b)};
      3'd6: ref_w = {{BIT{1'b0}}, i_data_a < i_data_b};
      3'd7: ref_w = {1'b0, ~i_data_a};
    endcase
  end
`ifdef ALU_CHK_CARRY_EN
  logic s1_exp_c_q, s1_got_c_q;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      s1_exp_c_q <= 1'b0;
      s1_got_c_q <= 1'b0;
    end else if (accept) begin
      s1_exp_c_q <= ref_w[BIT];
      s1_got_c_q <= i_data_c;
    end
  assign match = (s1_exp_y_q == s1_got_y_q) && (s1_exp_c_q == s1_got_c_q);
`else
  logic unused_c;
  assign unused_c = i_data_c ^ ref_w[BIT];
  assign match = (s1_exp_y_q == s1_got_y_q);
`endif
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      s1_vld_q   <= 1'b0;
      s1_func_q  <= '0;
      s1_exp_y_q <= '0;
      s1_got_y_q <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_func_q  <= i_func;
        s1_exp_y_q <= ref_w[BIT-1:0];
        s1_got_y_q <= i_data_y;
      end
    end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      pass_q      <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      err_func_q  <= '0;
      err_exp_y_q <= '0;
      err_got_y_q <= '0;
    end else if (i_start) begin
      pass_q      <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      err_func_q  <= '0;
      err_exp_y_q <= '0;
      err_got_y_q <= '0;
    end else if (s1_vld_q) begin
      if (match) pass_q <= (&pass_q) ? pass_q : pass_q + CNT_W'(1);
      else begin
        err_cnt_q <= (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
        if (!err_q) begin
          err_q       <= 1'b1;
          err_func_q  <= s1_func_q;
          err_exp_y_q <= s1_exp_y_q;
          err_got_y_q <= s1_got_y_q;
        end
      end
    end
  assign o_pass_cnt  = pass_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_err       = err_q;
  assign o_err_func  = err_func_q;
  assign o_err_exp_y = err_exp_y_q;
  assign o_err_got_y = err_got_y_q;
endmodule
